// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types, including the line-wide physical memory
// interface state and operation encodings.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } lc3b_pmem_state;

  typedef enum logic {
    PMEM_OP_READ,
    PMEM_OP_WRITE
  } lc3b_pmem_op;

  localparam int unsigned PMEM_OFFSET_BITS = 4;

endpackage

// File: rtl/pmem_responder_if.sv
// Line-wide pmem handshake between the cache (master) and the memory
// responder (slave); the request is held until the one-cycle resp pulse.
interface pmem_responder_if;
  import lc3b_types::*;

  logic     pmem_read;
  logic     pmem_write;
  lc3b_word pmem_address;
  lc3b_line pmem_wdata;
  lc3b_line pmem_rdata;
  logic     pmem_resp;
  logic     pmem_error;

  modport master (
    output pmem_read,
    output pmem_write,
    output pmem_address,
    output pmem_wdata,
    input  pmem_rdata,
    input  pmem_resp,
    input  pmem_error
  );

  modport slave (
    input  pmem_read,
    input  pmem_write,
    input  pmem_address,
    input  pmem_wdata,
    output pmem_rdata,
    output pmem_resp,
    output pmem_error
  );

endinterface

// File: rtl/pmem_line_array.sv
// DEPTH_LINES x 128-bit line storage: synchronous write, combinational read.
// Contents are deliberately not reset.
module pmem_line_array
  import lc3b_types::*;
#(
  parameter int unsigned DEPTH_LINES = 32,
  localparam int unsigned IDX_W      = $clog2(DEPTH_LINES)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] windex_i,
  input  lc3b_line         wdata_i,
  input  logic [IDX_W-1:0] rindex_i,
  output lc3b_line         rdata_o
);

  lc3b_line mem_q [DEPTH_LINES];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[windex_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rindex_i];

endmodule

// File: rtl/pmem_responder.sv
// Physical-memory responder: accepts a held pmem read/write, waits LATENCY
// cycles, then returns the line or commits the write with a one-cycle resp.
module pmem_responder
  import lc3b_types::*;
#(
  parameter int unsigned DEPTH_LINES = 32,
  parameter int unsigned LATENCY     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pmem_responder_if.slave  pmem
);

  localparam int unsigned IDX_W = $clog2(DEPTH_LINES);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  lc3b_pmem_state   state_q, state_d;
  lc3b_pmem_op      op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp_q, resp_d;
  lc3b_line         rdata_q, rdata_d;
  logic             error_q, error_d;

  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] rindex;
  lc3b_line         line_rd;
  logic             array_we;
  logic             req_both;
  logic             req_held;
  logic             unused_addr;

  // Upper address bits alias onto the array; offset bits are ignored.
  assign req_idx     = pmem.pmem_address[PMEM_OFFSET_BITS +: IDX_W];
  assign unused_addr = ^pmem.pmem_address;
  assign req_both    = pmem.pmem_read & pmem.pmem_write;
  assign req_held    = (op_q == PMEM_OP_WRITE) ? pmem.pmem_write : pmem.pmem_read;

  // With LATENCY=1 the array is read straight from the incoming address.
  assign rindex = (state_q == IDLE) ? req_idx : idx_q;

  pmem_line_array #(
    .DEPTH_LINES (DEPTH_LINES)
  ) u_array (
    .clk      (clk),
    .we_i     (array_we),
    .windex_i (idx_q),
    .wdata_i  (pmem.pmem_wdata),
    .rindex_i (rindex),
    .rdata_o  (line_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= PMEM_OP_READ;
      idx_q   <= '0;
      cnt_q   <= '0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    resp_d   = 1'b0;
    rdata_d  = rdata_q;
    error_d  = error_q;
    array_we = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pmem.pmem_read || pmem.pmem_write) begin
          op_d  = pmem.pmem_write ? PMEM_OP_WRITE : PMEM_OP_READ;
          idx_d = req_idx;
          cnt_d = CNT_LOAD;
          if (req_both) begin
            error_d = 1'b1;
          end
          if (LATENCY == 1) begin
            state_d = RESP;
            resp_d  = 1'b1;
            if (!pmem.pmem_write) begin
              rdata_d = line_rd;
            end
          end else begin
            state_d = BUSY;
          end
        end
      end

      BUSY: begin
        if (req_both) begin
          error_d = 1'b1;
        end
        cnt_d = cnt_q - CNT_ONE;
        // A dropped request abandons the operation before any side effect.
        if (!req_held) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_ONE) begin
          state_d = RESP;
          resp_d  = 1'b1;
          if (op_q == PMEM_OP_READ) begin
            rdata_d = line_rd;
          end
        end
      end

      RESP: begin
        state_d  = IDLE;
        array_we = (op_q == PMEM_OP_WRITE);
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pmem.pmem_resp  = resp_q;
  assign pmem.pmem_rdata = rdata_q;
  assign pmem.pmem_error = error_q;

endmodule

// File: doc/pmem_responder.md
Name: pmem_responder

Overview:
Physical-memory responder for the cache's line-wide pmem interface. The cache side is the initiator: it raises pmem_read or pmem_write and holds it until pmem_resp. This block decodes each request, waits a programmable latency, then commits the write or returns the read line with a one-cycle pmem_resp. It sits below the cache, in place of the behavioural memory, in simulation and FPGA builds.

Parameters:
DEPTH_LINES, 32, number of 128-bit lines stored; must be a power of two, at least 2.
LATENCY, 4, cycles from request acceptance to pmem_resp; must be at least 1.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
pmem_read  input  1  line read request, held until pmem_resp
pmem_write  input  1  line write request, held until pmem_resp
pmem_address  input  16 (lc3b_word)  byte address; bits [3:0] ignored
pmem_wdata  input  128 (lc3b_line)  write line, sampled in the resp cycle
pmem_rdata  output  128 (lc3b_line)  read line, registered
pmem_resp  output  1  single-cycle completion pulse
pmem_error  output  1  sticky protocol-violation flag

Behaviour:
- Reset (rst_n low, asynchronous): FSM goes to IDLE; pmem_resp=0; pmem_rdata=0; pmem_error=0; counter=0.
- Storage contents are not reset and are undefined until first written.
- Line index = pmem_address[4 +: log2(DEPTH_LINES)]. Higher address bits alias, i.e. the index wraps modulo DEPTH_LINES.
- FSM states: IDLE, BUSY, RESP.
- IDLE: if pmem_read or pmem_write is high at a clock edge:
  - latch the operation and the line index;
  - load counter = LATENCY-1;
  - go to BUSY, or go directly to RESP if LATENCY=1.
- BUSY: decrement the counter each cycle; when counter=1, go to RESP.
- Request-drop rule: if the latched request line (read or write) is low during BUSY, abort. Return to IDLE with no resp, no write commit, and pmem_rdata unchanged.
- RESP: pmem_resp=1 for exactly one cycle, then go to IDLE. A request that is still high in the cycle after RESP is treated as a new request, so the initiator must drop its request on the resp edge.
- Latency: the request is first high in IDLE at cycle 0; pmem_resp is high in cycle LATENCY.
- Read data: pmem_rdata is loaded with the array line on the edge entering RESP, so it is valid while pmem_resp=1. It holds until the next read completes; writes do not change it.
- Write commit: the array is written with pmem_wdata at the end of the RESP cycle, using the wdata value held during RESP.
- Read and write both high when sampled in IDLE:
  - set pmem_error (it stays set until reset);
  - treat the request as a write.
- pmem_error also sets if pmem_read and pmem_write are both high during BUSY. The operation continues.
- Back-to-back requests (a writeback followed by a fill) are separated by at least one IDLE cycle. Minimum period is LATENCY+1 cycles per request.
- Read-after-write to the same line returns the newly written data.
- Reset mid-operation: any in-flight write is discarded; no resp is issued.

Decomposition:
- Shared package lc3b_types additions:
  - lc3b_pmem_state enum {IDLE, BUSY, RESP};
  - constant PMEM_OFFSET_BITS=4;
  - lc3b_line and lc3b_word are reused.
- One sub-module, pmem_line_array: DEPTH_LINES x 128 storage with a synchronous write port (we, windex, wdata) and a combinational read port (rindex). The FSM, counter, error logic and output registers stay in pmem_responder.

Test Plan:
1. Reset then write, then read. LATENCY=4. Write 0x0123_4567_89AB_CDEF_0011_2233_4455_6677 to address 0x0040 -> pmem_resp high in cycle 4 only. A later read of 0x004C (same line, offset ignored) -> resp in cycle 4 and pmem_rdata equals that line.
2. Aliasing. DEPTH_LINES=32. Write line A to 0x0010 -> a read from 0x0210 returns A (index 1 wraps).
3. Back-to-back. Writeback to 0x0100 followed next cycle by a read of 0x0200 -> two resp pulses 5 cycles apart, and the read data is unaffected by the write.
4. Abort. Raise pmem_write to 0x0080 with data B; drop it in cycle 2 -> no resp. A subsequent read of 0x0080 returns the prior contents, not B.
5. Protocol error. Assert read and write together to 0x0030 with data C -> pmem_error=1 and remains 1. Resp occurs in cycle 4, and a later read returns C.
6. Async reset mid-BUSY. Pull rst_n low in cycle 2 of a write -> pmem_resp, pmem_rdata and pmem_error go to 0 immediately, the target line is unchanged, and a new request after reset completes normally.
